end_screen_ctrl: RTL and testbench
==================================

END_SCREEN_CTRL -- requirements
Module: end_screen_ctrl

Interface
REQ-001 SHALL provide parameter BLINK_FRAMES, default 30: frame ticks per overlay half-period (visible or hidden).
REQ-002 SHALL provide parameter BLINK_REPS, default 3: number of visible/hidden pairs shown before the steady overlay.
REQ-003 SHALL provide port pclk, input, 1: pixel clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL provide port vsync_in, input, 1: timing-chain vsync; its rising edge is the frame tick.
REQ-006 SHALL provide port collision, input, 1: one-cycle pulse, snake hit wall or self.
REQ-007 SHALL provide port win_cond, input, 1: one-cycle pulse, target length reached.
REQ-008 SHALL provide port key_restart, input, 1: debounced restart/start key level.
REQ-009 SHALL provide port score_clr_ack, input, 1: score block acknowledges that the clear is done.
REQ-010 SHALL provide port game_run, output, 1: enables snake motion and scoring.
REQ-011 SHALL provide port game_over, output, 1: drives the overlay's GAME OVER enable.
REQ-012 SHALL provide port victory, output, 1: drives the overlay's YOU WIN enable.
REQ-013 SHALL provide port score_clr_req, output, 1: request to clear the score.
REQ-014 SHALL provide port games_played, output, 8: count of finished games, saturating at 255.

Function
REQ-015 SHALL register every output; no combinational path from any input to any output.
REQ-016 SHALL form frame_tick = vsync_in AND NOT vsync_q, where vsync_q is vsync_in registered once.
REQ-017 SHALL form key_edge = key_restart AND NOT key_q, where key_q is key_restart registered once.
REQ-018 SHALL implement states IDLE, RUN, BLINK, HOLD and CLEAR.
REQ-019 IDLE: all outputs 0 except games_played; on key_edge, SHALL go to RUN and assert game_run on the same clock edge.
REQ-020 RUN: game_run=1; on collision, SHALL latch result=LOSE, and on win_cond, SHALL latch result=WIN.
REQ-021 RUN: if collision and win_cond occur in the same cycle, SHALL latch LOSE.
REQ-022 RUN: on either event, SHALL go to BLINK, drop game_run, increment games_played (saturating), clear the frame counter and set visible=1, all on the same edge.
REQ-023 BLINK: SHALL count frame_ticks; when the count reaches BLINK_FRAMES, SHALL toggle visible and reset the counter to 0.
REQ-024 BLINK: after 2*BLINK_REPS toggles, SHALL go to HOLD with visible=1.
REQ-025 BLINK: SHALL ignore key_edge.
REQ-026 game_over SHALL be 1 exactly when state is BLINK or HOLD, result=LOSE and visible=1; victory likewise with result=WIN; the two SHALL never be 1 together.
REQ-027 HOLD: overlay SHALL be steady; on key_edge, SHALL go to CLEAR, drop game_over/victory and assert score_clr_req on the same edge.
REQ-028 CLEAR: SHALL hold score_clr_req=1 until score_clr_ack is sampled 1; on that edge, SHALL go to RUN with score_clr_req=0 and game_run=1.
REQ-029 CLEAR: if score_clr_ack is already 1 on the first CLEAR cycle, SHALL complete after exactly one cycle of score_clr_req.
REQ-030 SHALL ignore collision and win_cond in IDLE, BLINK, HOLD and CLEAR.
REQ-031 frame_tick SHALL advance the blink counter only in BLINK.
REQ-032 key_restart held high across a state change SHALL NOT create a new key_edge.
REQ-033 SHALL size the frame counter by $clog2(BLINK_FRAMES+1) and the toggle counter by $clog2(2*BLINK_REPS+1).

Reset
REQ-034 On rst=1, SHALL immediately set state=IDLE, all outputs 0, games_played=0, counters 0, visible=0, result=LOSE, vsync_q=0 and key_q=0, regardless of current state.
REQ-035 rst asserted mid-BLINK or mid-CLEAR SHALL drop the overlay and score_clr_req with no completion of the pending handshake.

Verification (BLINK_FRAMES=2, BLINK_REPS=2)
REQ-036 Start: reset, then key_edge -> next edge game_run=1, game_over=0, victory=0, games_played=0.
REQ-037 Loss sequence: collision pulse in RUN -> next edge game_run=0, game_over=1, games_played=1; then game_over toggles every 2 frame ticks: 1,0,1,0 (4 half-periods); HOLD with game_over=1 after tick 8.
REQ-038 Simultaneous events: collision and win_cond in the same cycle -> game_over=1, victory=0.
REQ-039 Handshake: key_edge in HOLD -> score_clr_req=1 with game_over=0; ack held 0 for 5 cycles keeps req=1; ack=1 -> next edge req=0 and game_run=1.
REQ-040 Ignore and saturate: key pressed during BLINK and win_cond during HOLD -> no state change; 256 finished games -> games_played stays 255.
REQ-041 Reset mid-BLINK with victory=1 -> outputs 0 asynchronously; key_edge after release -> RUN.

Source files
------------

// File: rtl/end_screen_ctrl.sv
// End-of-game screen controller: runs a game, then blinks the GAME OVER / YOU WIN overlay,
// shows it steadily, and clears the score through a handshake before the next game starts.
module end_screen_ctrl #(
   parameter int BLINK_FRAMES = 30,
   parameter int BLINK_REPS   = 3
) (
   input  logic       pclk,
   input  logic       rst,
   input  logic       vsync_in,
   input  logic       collision,
   input  logic       win_cond,
   input  logic       key_restart,
   input  logic       score_clr_ack,
   output logic       game_run,
   output logic       game_over,
   output logic       victory,
   output logic       score_clr_req,
   output logic [7:0] games_played
);

   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam int TW = $clog2(2 * BLINK_REPS + 1);
   localparam logic [FW-1:0] FRAME_LAST  = FW'(BLINK_FRAMES);
   localparam logic [TW-1:0] TOGGLE_LAST = TW'(2 * BLINK_REPS);

   typedef enum logic [2:0] {IDLE, RUN, BLINK, HOLD, CLEAR} state_t;
   typedef enum logic {LOSE = 1'b0, WIN = 1'b1} result_t;

   state_t        state, state_n;
   result_t       result, result_n;
   logic          visible, visible_n;
   logic [FW-1:0] frame_cnt, frame_cnt_n;
   logic [TW-1:0] toggle_cnt, toggle_cnt_n;
   logic          vsync_q, key_q;
   logic          game_run_n, game_over_n, victory_n, score_clr_req_n;
   logic [7:0]    games_played_n;
   logic          overlay_n;
   logic          frame_tick, key_edge;

   assign frame_tick = vsync_in & ~vsync_q;
   assign key_edge   = key_restart & ~key_q;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         result        <= LOSE;
         visible       <= 1'b0;
         frame_cnt     <= '0;
         toggle_cnt    <= '0;
         vsync_q       <= 1'b0;
         key_q         <= 1'b0;
         game_run      <= 1'b0;
         game_over     <= 1'b0;
         victory       <= 1'b0;
         score_clr_req <= 1'b0;
         games_played  <= 8'd0;
      end else begin
         state         <= state_n;
         result        <= result_n;
         visible       <= visible_n;
         frame_cnt     <= frame_cnt_n;
         toggle_cnt    <= toggle_cnt_n;
         vsync_q       <= vsync_in;
         key_q         <= key_restart;
         game_run      <= game_run_n;
         game_over     <= game_over_n;
         victory       <= victory_n;
         score_clr_req <= score_clr_req_n;
         games_played  <= games_played_n;
      end
   end

   // Outputs are decoded from the next-state values so they change on the same edge as the state.
   always_comb begin
      state_n        = state;
      result_n       = result;
      visible_n      = visible;
      frame_cnt_n    = frame_cnt;
      toggle_cnt_n   = toggle_cnt;
      games_played_n = games_played;

      case (state)
         IDLE: begin
            if (key_edge) state_n = RUN;
         end
         RUN: begin
            if (collision || win_cond) begin
               state_n        = BLINK;
               result_n       = collision ? LOSE : WIN;
               frame_cnt_n    = '0;
               toggle_cnt_n   = '0;
               visible_n      = 1'b1;
               games_played_n = (games_played == 8'hFF) ? games_played : games_played + 8'd1;
            end
         end
         BLINK: begin
            if (frame_tick) begin
               if (frame_cnt + FW'(1) == FRAME_LAST) begin
                  frame_cnt_n = '0;
                  visible_n   = ~visible;
                  if (toggle_cnt + TW'(1) == TOGGLE_LAST) begin
                     state_n      = HOLD;
                     visible_n    = 1'b1;
                     toggle_cnt_n = '0;
                  end else begin
                     toggle_cnt_n = toggle_cnt + TW'(1);
                  end
               end else begin
                  frame_cnt_n = frame_cnt + FW'(1);
               end
            end
         end
         HOLD: begin
            if (key_edge) state_n = CLEAR;
         end
         CLEAR: begin
            if (score_clr_ack) state_n = RUN;
         end
         default: state_n = IDLE;
      endcase

      overlay_n       = ((state_n == BLINK) || (state_n == HOLD)) && visible_n;
      game_run_n      = (state_n == RUN);
      game_over_n     = overlay_n && (result_n == LOSE);
      victory_n       = overlay_n && (result_n == WIN);
      score_clr_req_n = (state_n == CLEAR);
   end

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Randomized scoreboard bench for end_screen_ctrl, checked against a frame-count reference model.
module tb_end_screen_ctrl;
   localparam int BF = 2;
   localparam int BR = 2;
   localparam int BLINK_TICKS = 2 * BR * BF;

   logic       pclk = 1'b0;
   logic       rst = 1'b0;
   logic       vsync_in = 1'b0, collision = 1'b0, win_cond = 1'b0;
   logic       key_restart = 1'b0, score_clr_ack = 1'b0;
   logic       game_run, game_over, victory, score_clr_req;
   logic [7:0] games_played;

   typedef struct packed {
      logic       run;
      logic       over;
      logic       vic;
      logic       req;
      logic [7:0] played;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: game phase flags plus the number of frame ticks seen since the game ended.
   bit m_run, m_end, m_clr, m_lost, m_vprev, m_kprev;
   int m_ticks, m_played;

   end_screen_ctrl #(.BLINK_FRAMES(BF), .BLINK_REPS(BR)) dut (
      .pclk(pclk), .rst(rst), .vsync_in(vsync_in), .collision(collision),
      .win_cond(win_cond), .key_restart(key_restart), .score_clr_ack(score_clr_ack),
      .game_run(game_run), .game_over(game_over), .victory(victory),
      .score_clr_req(score_clr_req), .games_played(games_played)
   );

   always #5 pclk = ~pclk;

   task automatic model_reset();
      m_run = 0; m_end = 0; m_clr = 0; m_lost = 1; m_vprev = 0; m_kprev = 0;
      m_ticks = 0; m_played = 0;
   endtask

   task automatic model_step();
      bit fe, ke;
      fe = vsync_in && !m_vprev;
      ke = key_restart && !m_kprev;
      if (m_run) begin
         if (collision || win_cond) begin
            m_run = 0; m_end = 1; m_ticks = 0;
            m_lost = collision;
            if (m_played < 255) m_played++;
         end
      end else if (m_end) begin
         if (m_ticks >= BLINK_TICKS) begin
            if (ke) begin m_end = 0; m_clr = 1; end
         end else if (fe) begin
            m_ticks++;
         end
      end else if (m_clr) begin
         if (score_clr_ack) begin m_clr = 0; m_run = 1; end
      end else if (ke) begin
         m_run = 1;
      end
      m_vprev = vsync_in;
      m_kprev = key_restart;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      bit   ovl;
      ovl = m_end && ((m_ticks >= BLINK_TICKS) || (((m_ticks / BF) % 2) == 0));
      e.run    = m_run;
      e.over   = ovl && m_lost;
      e.vic    = ovl && !m_lost;
      e.req    = m_clr;
      e.played = 8'(m_played);
      return e;
   endfunction

   task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput(input string tag, input exp_t e);
      check_val({tag, "_game_run"},      {7'd0, game_run},      {7'd0, e.run});
      check_val({tag, "_game_over"},     {7'd0, game_over},     {7'd0, e.over});
      check_val({tag, "_victory"},       {7'd0, victory},       {7'd0, e.vic});
      check_val({tag, "_score_clr_req"}, {7'd0, score_clr_req}, {7'd0, e.req});
      check_val({tag, "_games_played"},  games_played,          e.played);
   endtask

   // Drive one cycle of inputs on the falling edge and queue the model's view of the next edge.
   task automatic applyStimulus(input logic r, input logic v, input logic c, input logic w,
                                input logic k, input logic a);
      logic was_rst;
      @(negedge pclk);
      was_rst = rst;
      rst = r; vsync_in = v; collision = c; win_cond = w; key_restart = k; score_clr_ack = a;
      if (r) model_reset();
      else   model_step();
      exp_q.push_back(model_out());
      if (r && !was_rst) begin
         #1;
         checkOutput("async_reset", exp_t'(0));
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge pclk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("cycle", e);
         end
      end
   end

   initial begin : stimulus
      logic r, v, c, w, k, a;
      int   sel;
      model_reset();
      rst = 1'b1;
      #2;
      checkOutput("reset", exp_t'(0));

      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Mixed traffic with occasional resets landing in arbitrary phases.
      r = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         if (r) r = ($urandom_range(0, 1) == 0);
         else   r = ($urandom_range(0, 299) == 0);
         v   = ($urandom_range(0, 3) == 0);
         sel = $urandom_range(0, 15);
         c   = (sel == 0) || (sel == 2);
         w   = (sel == 1) || (sel == 2);
         k   = ($urandom_range(0, 5) == 0) ? ~key_restart : key_restart;
         a   = ($urandom_range(0, 2) == 0);
         applyStimulus(r, v, c, w, k, a);
      end

      // Dense games with no resets so the played counter runs into saturation.
      for (int i = 0; i < 12000; i++) begin
         v   = ~vsync_in;
         sel = $urandom_range(0, 7);
         c   = (sel == 0) || (sel == 2);
         w   = (sel == 1) || (sel == 2);
         k   = ($urandom_range(0, 1) == 0) ? ~key_restart : key_restart;
         a   = ($urandom_range(0, 1) == 0);
         applyStimulus(1'b0, v, c, w, k, a);
      end

      @(posedge pclk);
      #2;
      check_val("queue_drained", 8'(exp_q.size()), 8'd0);
      check_val("games_played_saturated", games_played, 8'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
